instruction_fetch_unit: RTL and testbench

- Fetch stage directly upstream of the instruction memory.
- Owns the program counter (PC) and drives the word-indexed memory address.
- Captures the returned instruction, combinational in the same cycle, into an IF/ID pipeline register for the decode stage.
- Supports decode-side stall, flush and branch/jump redirect.

---
 rtl/cpu_fetch_pkg.sv | 19 +
 rtl/if_id_pipe_reg.sv | 39 +++
 rtl/instruction_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_instruction_fetch_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-stage definitions: default widths, the NOP encoding and the
// IF/ID pipeline register layout.
package cpu_fetch_pkg;

    localparam int unsigned DEFAULT_ADDR_W    = 32;
    localparam int unsigned DEFAULT_INSTR_W   = 32;
    localparam int unsigned DEFAULT_MEM_DEPTH = 100;

    localparam logic [DEFAULT_INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

    // IF/ID contents handed to decode; field widths follow the default widths.
    typedef struct packed {
        logic [DEFAULT_INSTR_W-1:0] instruction;
        logic [DEFAULT_ADDR_W-1:0]  pc;
        logic [DEFAULT_ADDR_W-1:0]  pc_plus1;
        logic                       valid;
    } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register. Priority: reset > bubble > hold > load.
// A bubble clears the instruction and valid bit but keeps the pc fields.
module if_id_pipe_reg
    import cpu_fetch_pkg::*;
(
    input  logic   clk,
    input  logic   rst_n,
    input  logic   load,
    input  logic   bubble,
    input  logic   hold,
    input  if_id_t d,
    output if_id_t q
);

    if_id_t q_d;

    // Next-state selection for the IF/ID register.
    always_comb begin
        q_d = q;
        if (bubble) begin
            q_d.instruction = NOP_INSTR;
            q_d.valid       = 1'b0;
        end else if (hold) begin
            q_d = q;
        end else if (load) begin
            q_d = d;
        end
    end

    // IF/ID state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= '{instruction: NOP_INSTR, pc: '0, pc_plus1: '0, valid: 1'b0};
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: owns the word-indexed PC, drives the instruction
// memory address and captures the returned word into the IF/ID register.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
// ADDR_W and INSTR_W must match the if_id_t field widths in cpu_fetch_pkg.
module instruction_fetch_unit
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned INSTR_W   = DEFAULT_INSTR_W,
    parameter int unsigned MEM_DEPTH = DEFAULT_MEM_DEPTH,
    parameter int unsigned RESET_PC  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               flush,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_target,
    output logic [ADDR_W-1:0]  imem_address,
    input  logic [INSTR_W-1:0] imem_instruction,
    output logic [INSTR_W-1:0] if_id_instruction,
    output logic [ADDR_W-1:0]  if_id_pc,
    output logic [ADDR_W-1:0]  if_id_pc_plus1,
    output logic               if_id_valid,
    output logic               addr_fault
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]        perf_fetch_cnt,
    output logic [31:0]        perf_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] LastPc  = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] DepthA  = ADDR_W'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ResetPc = ADDR_W'(RESET_PC);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] next_seq_pc;
    logic              fault_q, fault_d;
    logic              bubble;
    logic              hold;
    if_id_t            if_id_d;
    if_id_t            if_id_q;

    // Sequential successor of the PC, wrapping at the end of memory.
    always_comb begin
        next_seq_pc = (pc_q == LastPc) ? '0 : pc_q + ADDR_W'(1);
    end

    // PC and fault next-state: redirect > flush > stall > sequential.
    always_comb begin
        pc_d    = next_seq_pc;
        fault_d = fault_q;
        if (redirect_valid) begin
            if (redirect_target < DepthA) begin
                pc_d = redirect_target;
            end else begin
                pc_d    = ResetPc;
                fault_d = 1'b1;
            end
        end else if (flush) begin
            pc_d = next_seq_pc;
        end else if (stall) begin
            pc_d = pc_q;
        end
    end

    // Control and data for the IF/ID register; a redirect squashes the
    // wrong-path word fetched this cycle, and flush overrides stall.
    always_comb begin
        bubble                = redirect_valid | flush;
        hold                  = stall;
        if_id_d.instruction   = imem_instruction;
        if_id_d.pc            = pc_q;
        if_id_d.pc_plus1      = next_seq_pc;
        if_id_d.valid         = 1'b1;
    end

    // PC and sticky fault registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= ResetPc;
            fault_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    if_id_pipe_reg u_if_id (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (1'b1),
        .bubble (bubble),
        .hold   (hold),
        .d      (if_id_d),
        .q      (if_id_q)
    );

    // Memory address comes straight from the PC register.
    always_comb begin
        imem_address      = pc_q;
        if_id_instruction = if_id_q.instruction;
        if_id_pc          = if_id_q.pc;
        if_id_pc_plus1    = if_id_q.pc_plus1;
        if_id_valid       = if_id_q.valid;
        addr_fault        = fault_q;
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        fetch_evt;
    logic        stall_evt;

    // A fetch counts when IF/ID is loaded with a valid instruction.
    always_comb begin
        fetch_evt = ~redirect_valid & ~flush & ~stall;
        stall_evt = ~redirect_valid & ~flush & stall;
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (fetch_evt && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
            if (stall_evt && (stall_cnt_q != 32'hFFFF_FFFF)) begin
                stall_cnt_q <= stall_cnt_q + 32'd1;
            end
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_address;
    logic [31:0] imem_instruction;
    logic [31:0] if_id_instruction;
    logic [31:0] if_id_pc;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
    logic        addr_fault;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    int checks;
    int failures;

    logic [31:0] mem [0:99];

    assign imem_instruction = (imem_address < 32'd100) ? mem[imem_address] : 32'hDEAD_BEEF;

    instruction_fetch_unit dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .stall             (stall),
        .flush             (flush),
        .redirect_valid    (redirect_valid),
        .redirect_target   (redirect_target),
        .imem_address      (imem_address),
        .imem_instruction  (imem_instruction),
        .if_id_instruction (if_id_instruction),
        .if_id_pc          (if_id_pc),
        .if_id_pc_plus1    (if_id_pc_plus1),
        .if_id_valid       (if_id_valid),
        .addr_fault        (addr_fault)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_fetch_cnt    (perf_fetch_cnt),
        .perf_stall_cnt    (perf_stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall           = 1'b0;
        flush           = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'd0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (imem_address !== 32'd0) begin
            failures++;
            $display("FAIL reset_addr got=%0d exp=0", imem_address);
        end
        checks++;
        if (if_id_instruction !== 32'h0 || if_id_pc !== 32'd0 || if_id_pc_plus1 !== 32'd0) begin
            failures++;
            $display("FAIL reset_ifid got=%h/%0d/%0d exp=0/0/0",
                     if_id_instruction, if_id_pc, if_id_pc_plus1);
        end
        checks++;
        if (if_id_valid !== 1'b0 || addr_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b%b exp=00", if_id_valid, addr_fault);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_words [0:3];
        exp_words[0] = 32'h8001_0010;
        exp_words[1] = 32'h0001_1000;
        exp_words[2] = 32'h8403_0010;
        exp_words[3] = 32'h0403_0010;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (imem_address !== 32'(i + 1) || if_id_pc !== 32'(i) ||
                if_id_pc_plus1 !== 32'(i + 1) || if_id_instruction !== exp_words[i] ||
                if_id_valid !== 1'b1) begin
                failures++;
                $display("FAIL seq_%0d got addr=%0d pc=%0d pc1=%0d ins=%h v=%b exp addr=%0d pc=%0d pc1=%0d ins=%h v=1",
                         i, imem_address, if_id_pc, if_id_pc_plus1, if_id_instruction,
                         if_id_valid, i + 1, i, i + 1, exp_words[i]);
            end
        end
    endtask

    task automatic test_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (imem_address !== 32'd2 || if_id_pc !== 32'd1 ||
                if_id_instruction !== 32'h0001_1000 || if_id_valid !== 1'b1) begin
                failures++;
                $display("FAIL stall_hold_%0d got addr=%0d pc=%0d ins=%h v=%b exp addr=2 pc=1 ins=00011000 v=1",
                         i, imem_address, if_id_pc, if_id_instruction, if_id_valid);
            end
        end
        stall = 1'b0;
        step();
        checks++;
        if (imem_address !== 32'd3 || if_id_pc !== 32'd2 || if_id_instruction !== 32'h8403_0010) begin
            failures++;
            $display("FAIL stall_release got addr=%0d pc=%0d ins=%h exp addr=3 pc=2 ins=84030010",
                     imem_address, if_id_pc, if_id_instruction);
        end
    endtask

    task automatic test_redirect();
        // PC is 3 on entry
        redirect_valid  = 1'b1;
        redirect_target = 32'd5;
        step();
        redirect_valid = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || imem_address !== 32'd5 ||
            if_id_pc !== 32'd2) begin
            failures++;
            $display("FAIL redirect_bubble got v=%b ins=%h addr=%0d pc=%0d exp v=0 ins=0 addr=5 pc=2",
                     if_id_valid, if_id_instruction, imem_address, if_id_pc);
        end
        step();
        checks++;
        if (if_id_valid !== 1'b1 || if_id_pc !== 32'd5 || if_id_instruction !== 32'h9087_0008 ||
            if_id_pc_plus1 !== 32'd6 || imem_address !== 32'd6) begin
            failures++;
            $display("FAIL redirect_target got v=%b pc=%0d ins=%h pc1=%0d addr=%0d exp v=1 pc=5 ins=90870008 pc1=6 addr=6",
                     if_id_valid, if_id_pc, if_id_instruction, if_id_pc_plus1, imem_address);
        end
    endtask

    task automatic test_fault();
        redirect_valid  = 1'b1;
        redirect_target = 32'd150;
        step();
        checks++;
        if (addr_fault !== 1'b1 || imem_address !== 32'd0 || if_id_valid !== 1'b0) begin
            failures++;
            $display("FAIL fault_set got f=%b addr=%0d v=%b exp f=1 addr=0 v=0",
                     addr_fault, imem_address, if_id_valid);
        end
        // valid redirect while stalled: stall ignored, fault stays
        redirect_target = 32'd7;
        stall           = 1'b1;
        step();
        redirect_valid = 1'b0;
        stall          = 1'b0;
        checks++;
        if (addr_fault !== 1'b1 || imem_address !== 32'd7) begin
            failures++;
            $display("FAIL fault_sticky got f=%b addr=%0d exp f=1 addr=7", addr_fault, imem_address);
        end
        step();
        checks++;
        if (addr_fault !== 1'b1 || if_id_pc !== 32'd7 || if_id_instruction !== 32'hC000_0007) begin
            failures++;
            $display("FAIL fault_after_fetch got f=%b pc=%0d ins=%h exp f=1 pc=7 ins=c0000007",
                     addr_fault, if_id_pc, if_id_instruction);
        end
        do_reset();
        checks++;
        if (addr_fault !== 1'b0) begin
            failures++;
            $display("FAIL fault_clear got=%b exp=0", addr_fault);
        end
    endtask

    task automatic test_wrap_and_flush();
        redirect_valid  = 1'b1;
        redirect_target = 32'd99;
        step();
        redirect_valid = 1'b0;
        step();
        checks++;
        if (if_id_pc !== 32'd99 || if_id_pc_plus1 !== 32'd0 || imem_address !== 32'd0 ||
            if_id_instruction !== 32'hC000_0063 || if_id_valid !== 1'b1) begin
            failures++;
            $display("FAIL wrap got pc=%0d pc1=%0d addr=%0d ins=%h v=%b exp pc=99 pc1=0 addr=0 ins=c0000063 v=1",
                     if_id_pc, if_id_pc_plus1, imem_address, if_id_instruction, if_id_valid);
        end
        stall = 1'b1;
        flush = 1'b1;
        step();
        stall = 1'b0;
        flush = 1'b0;
        checks++;
        if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc !== 32'd99 ||
            if_id_pc_plus1 !== 32'd0 || imem_address !== 32'd1) begin
            failures++;
            $display("FAIL stall_flush got v=%b ins=%h pc=%0d pc1=%0d addr=%0d exp v=0 ins=0 pc=99 pc1=0 addr=1",
                     if_id_valid, if_id_instruction, if_id_pc, if_id_pc_plus1, imem_address);
        end
    endtask

    task automatic test_reset_during_stall();
        do_reset();
        step();
        step();
        stall = 1'b1;
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (imem_address !== 32'd0 || if_id_instruction !== 32'h0 || if_id_pc !== 32'd0 ||
            if_id_pc_plus1 !== 32'd0 || if_id_valid !== 1'b0 || addr_fault !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_stall got addr=%0d ins=%h pc=%0d pc1=%0d v=%b f=%b exp all zero",
                     imem_address, if_id_instruction, if_id_pc, if_id_pc_plus1, if_id_valid,
                     addr_fault);
        end
        rst_n = 1'b1;
        stall = 1'b0;
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        do_reset();
        checks++;
        if (perf_fetch_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            failures++;
            $display("FAIL perf_reset got %0d/%0d exp 0/0", perf_fetch_cnt, perf_stall_cnt);
        end
        for (int i = 0; i < 10; i++) step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) step();
        stall = 1'b0;
        checks++;
        if (perf_fetch_cnt !== 32'd10 || perf_stall_cnt !== 32'd3) begin
            failures++;
            $display("FAIL perf_counts got %0d/%0d exp 10/3", perf_fetch_cnt, perf_stall_cnt);
        end
    endtask
`endif

    initial begin
        checks   = 0;
        failures = 0;
        for (int i = 0; i < 100; i++) mem[i] = 32'hC000_0000 | 32'(i);
        mem[0] = 32'h8001_0010;
        mem[1] = 32'h0001_1000;
        mem[2] = 32'h8403_0010;
        mem[3] = 32'h0403_0010;
        mem[5] = 32'h9087_0008;
        rst_n  = 1'b0;
        idle_inputs();

        test_reset();
        test_sequential();
        test_stall();
        test_redirect();
        test_fault();
        test_wrap_and_flush();
        test_reset_during_stall();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
